shifter_pipelined: RTL and testbench

//  - Parametrised, 2-stage pipelined barrel shifter for the ALU/execute path.
//  - Supports logical left, logical right and arithmetic right shifts; rotate right is optional.
//  - Provides carry-out and zero flags.
//  - valid/ready handshake on both sides; sustains 1 op/cycle when not stalled.

---
 rtl/shifter_pipelined_if.sv | 30 +++
 rtl/shifter_pipelined.sv | 112 +++++++++++
 tb/tb_shifter_pipelined.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shifter_pipelined_if.sv
// Handshake bundle for the pipelined shifter.
// Valid/ready rule on both sides: a transfer happens on a rising clock edge
// when valid and ready are both high. Once valid is raised, the payload holds
// stable until that transfer.
// The slave modport is the shifter; the master modport is the requester/consumer.
interface shifter_pipelined_if #(
    parameter int N = 32,
    parameter int S = $clog2(N)
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [S-1:0] shamt;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         carry;
    logic         zero;

    modport master (
        output in_valid, in_data, shamt, op, out_ready,
        input  in_ready, out_valid, out_data, carry, zero
    );

    modport slave (
        input  in_valid, in_data, shamt, op, out_ready,
        output in_ready, out_valid, out_data, carry, zero
    );
endinterface

// File: rtl/shifter_pipelined.sv
// Two-stage pipelined barrel shifter: SLL, SRL, SRA and optional ROR.
// Stage 1 resolves shamt[LO-1:0] and the carry flag. Stage 2 resolves
// shamt[S-1:LO] and the zero flag.
// Optional feature macro: SHIFTER_ROTATE_EN. When it is defined, op=11 rotates
// right. When it is undefined, op=11 passes the operand through with carry=0.
module shifter_pipelined #(
    parameter int N  = 32,
    parameter int S  = $clog2(N),
    parameter int LO = S / 2
) (
    input  logic                clk,
    input  logic                rst,
    shifter_pipelined_if.slave  bus
);
    localparam int HI = S - LO;

    // One shift step for the given op. Two partial steps compose to the full
    // shift. For SRA, the MSB survives stage 1, so stage 2 still sees the
    // original sign bit.
    function automatic logic [N-1:0] shift_op(input logic [N-1:0] x,
                                              input logic [1:0]   o,
                                              input logic [S-1:0] amt);
        logic [N-1:0] r;
        r = x;
        case (o)
            2'b00:   r = x << amt;
            2'b01:   r = x >> amt;
            2'b10:   r = $signed(x) >>> amt;
`ifdef SHIFTER_ROTATE_EN
            2'b11:   r = N'({x, x} >> amt);
`endif
            default: r = x;
        endcase
        return r;
    endfunction

    logic         s1_valid, s2_valid;
    logic [N-1:0] s1_data, s2_data;
    logic [1:0]   s1_op;
    logic [HI-1:0] s1_hi;
    logic         s1_carry, s2_carry, s2_zero;
    logic         s1_adv, s2_adv;
    logic [N-1:0] s1_next, s2_next;
    logic [S-1:0] idx_sll, idx_sr;
    logic         carry_next;

    assign s2_adv        = !s2_valid || bus.out_ready;
    assign s1_adv        = !s1_valid || s2_adv;
    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.carry     = s2_carry;
    assign bus.zero      = s2_zero;

    // Carry from the full shift amount: the last operand bit that falls off the end.
    always_comb begin
        idx_sll    = '0 - bus.shamt;       // N - shamt, modulo N
        idx_sr     = bus.shamt - S'(1);
        carry_next = 1'b0;
        if (bus.shamt != '0) begin
            case (bus.op)
                2'b00:   carry_next = bus.in_data[idx_sll];
                2'b01,
                2'b10:   carry_next = bus.in_data[idx_sr];
`ifdef SHIFTER_ROTATE_EN
                // The bit that wraps into the MSB is in_data[shamt-1].
                2'b11:   carry_next = bus.in_data[idx_sr];
`endif
                default: carry_next = 1'b0;
            endcase
        end
    end

    // Partial shifts for each stage: low shamt bits in stage 1, high bits in stage 2.
    always_comb begin
        s1_next = shift_op(bus.in_data, bus.op, {{HI{1'b0}}, bus.shamt[LO-1:0]});
        s2_next = shift_op(s1_data, s1_op, {s1_hi, {LO{1'b0}}});
    end

    // Pipeline registers. A stage loads whenever the stage downstream can take its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_op    <= '0;
            s1_hi    <= '0;
            s1_carry <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_carry <= 1'b0;
            s2_zero  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_data  <= s1_next;
                    s1_op    <= bus.op;
                    s1_hi    <= bus.shamt[S-1:LO];
                    s1_carry <= carry_next;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data  <= s2_next;
                    s2_carry <= s1_carry;
                    s2_zero  <= (s2_next == '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_shifter_pipelined.sv
// Testbench for shifter_pipelined (N=32). It uses fixed-latency table vectors,
// reset and back-pressure sequences, and a random stream checked against a
// golden model through an expected-result queue.
module tb_shifter_pipelined;
    localparam int N = 32;
    localparam int S = 5;
    localparam int W = N + 2;   // {data, carry, zero}

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shifter_pipelined_if #(.N(N)) bus();

    shifter_pipelined #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [1:0]   op;
        logic [S-1:0] sh;
        logic [N-1:0] din;
        logic [N-1:0] dout;
        logic         c;
        logic         z;
    } vec_t;

    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int n_out  = 0;
    int n_acc  = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Golden model, written bit by bit from the operation definitions.
    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [S-1:0] sh,
                                           input logic [N-1:0] x);
        logic [N-1:0] r;
        logic c;
        int s;
        s = int'(sh);
        r = x;
        c = 1'b0;
        case (o)
            2'b00: begin
                for (int i = 0; i < N; i++) r[i] = (i >= s) ? x[i-s] : 1'b0;
                if (s != 0) c = x[N-s];
            end
            2'b01: begin
                for (int i = 0; i < N; i++) r[i] = (i + s < N) ? x[i+s] : 1'b0;
                if (s != 0) c = x[s-1];
            end
            2'b10: begin
                for (int i = 0; i < N; i++) r[i] = (i + s < N) ? x[i+s] : x[N-1];
                if (s != 0) c = x[s-1];
            end
            default: begin
`ifdef SHIFTER_ROTATE_EN
                for (int i = 0; i < N; i++) r[i] = x[(i+s)%N];
                c = (s != 0) ? r[N-1] : 1'b0;
`else
                r = x;
                c = 1'b0;
`endif
            end
        endcase
        return {r, c, (r == '0)};
    endfunction

    // One clock cycle. Inputs are already set at the negedge. Outputs and the
    // accept decision are sampled just after that, and the cycle ends at the next negedge.
    task automatic tick(output bit acc);
        logic [W-1:0] e;
        acc = 1'b0;
        #1;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected no output", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_data",  bus.out_data, e[W-1:2]);
                check("sb_carry", N'(bus.carry), N'(e[1]));
                check("sb_zero",  N'(bus.zero),  N'(e[0]));
            end
        end
        if (!rst && bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            exp_q.push_back(model(bus.op, bus.shamt, bus.in_data));
            acc = 1'b1;
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        bus.op    = 2'($urandom_range(0, 3));
        bus.shamt = S'($urandom_range(0, N-1));
        case ($urandom_range(0, 7))
            0:       bus.in_data = '0;
            1:       bus.in_data = 32'h8000_0000;
            2:       bus.in_data = 32'hFFFF_FFFF;
            default: bus.in_data = $urandom;
        endcase
    endtask

    vec_t vecs[10];
    bit acc;
    logic [N-1:0] held;
    int sent, cyc, base_out, base_acc;

    initial begin
        vecs[0] = '{2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 5'd4,  32'h8000_00F0, 32'hF800_000F, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 5'd4,  32'h8000_00F0, 32'h0800_000F, 1'b0, 1'b0};
        vecs[3] = '{2'b00, 5'd1,  32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[5] = '{2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[6] = '{2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0};
        vecs[7] = '{2'b00, 5'd16, 32'h0000_0003, 32'h0003_0000, 1'b0, 1'b0};
        vecs[8] = '{2'b10, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1};
`ifdef SHIFTER_ROTATE_EN
        vecs[9] = '{2'b11, 5'd1,  32'h0000_0003, 32'h8000_0001, 1'b1, 1'b0};
`else
        vecs[9] = '{2'b11, 5'd1,  32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0};
`endif

        // Reset held for 2 cycles with a request pending: nothing may come out.
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'h0000_0001;
        bus.shamt = 5'd1;
        bus.op = 2'b00;
        bus.out_ready = 1'b1;
        @(negedge clk);
        tick(acc);
        tick(acc);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_out_valid", N'(bus.out_valid), '0);
        check("rst_in_ready",  N'(bus.in_ready),  N'(1));
        check("rst_out_data",  bus.out_data, '0);
        check("rst_carry_zero", N'({bus.carry, bus.zero}), '0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick(acc);
        check("rst_no_output", N'(n_out), '0);

        // Table vectors with exact latency: accept at edge k, output visible after edge k+1.
        foreach (vecs[k]) begin
            bus.in_valid = 1'b1;
            bus.op = vecs[k].op;
            bus.shamt = vecs[k].sh;
            bus.in_data = vecs[k].din;
            #1;
            check($sformatf("vec%0d_in_ready", k), N'(bus.in_ready), N'(1));
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            check($sformatf("vec%0d_early", k), N'(bus.out_valid), '0);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_valid", k), N'(bus.out_valid), N'(1));
            check($sformatf("vec%0d_data", k),  bus.out_data, vecs[k].dout);
            check($sformatf("vec%0d_carry", k), N'(bus.carry), N'(vecs[k].c));
            check($sformatf("vec%0d_zero", k),  N'(bus.zero),  N'(vecs[k].z));
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_drained", k), N'(bus.out_valid), '0);
            @(negedge clk);
        end

        // Reset arriving while an op sits in stage 1 discards it.
        bus.in_valid = 1'b1;
        bus.op = 2'b01;
        bus.shamt = 5'd3;
        bus.in_data = 32'h1234_5678;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_valid0", N'(bus.out_valid), '0);
        @(negedge clk);
        #1;
        check("midrst_valid1", N'(bus.out_valid), '0);
        check("midrst_in_ready", N'(bus.in_ready), N'(1));
        @(negedge clk);

        // Back-pressure: 4 ops, out_ready low for 3 cycles.
        base_out = n_out;
        sent = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            rand_inputs();
            #1;
            check($sformatf("bp_in_ready%0d", c), N'(bus.in_ready), N'(c < 2));
            if (c == 2) begin
                check("bp_out_valid", N'(bus.out_valid), N'(1));
                held = bus.out_data;
            end
            tick(acc);
            if (acc) sent++;
        end
        #1;
        check("bp_stable", bus.out_data, held);
        check("bp_still_valid", N'(bus.out_valid), N'(1));
        @(negedge clk);
        bus.out_ready = 1'b1;
        cyc = 0;
        while (sent < 4 && cyc < 20) begin
            bus.in_valid = 1'b1;
            rand_inputs();
            tick(acc);
            if (acc) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            tick(acc);
            cyc++;
        end
        check("bp_sent", N'(sent), N'(4));
        check("bp_outputs", N'(n_out - base_out), N'(4));
        check("bp_queue_empty", N'(exp_q.size()), '0);

        // Throughput: 16 back-to-back ops with out_ready high, one accepted every cycle.
        base_acc = n_acc;
        base_out = n_out;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            rand_inputs();
            tick(acc);
        end
        bus.in_valid = 1'b0;
        check("tp_accepts", N'(n_acc - base_acc), N'(16));
        check("tp_out_streaming", N'(n_out - base_out), N'(14));
        tick(acc);
        tick(acc);
        check("tp_outputs", N'(n_out - base_out), N'(16));

        // Random stream with random back-pressure.
        base_acc = n_acc;
        cyc = 0;
        bus.in_valid = 1'b0;
        while ((n_acc - base_acc) < 10000 && cyc < 60000) begin
            if (!bus.in_valid) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                rand_inputs();
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) bus.in_valid = 1'b0;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            tick(acc);
            cyc++;
        end
        check("rand_accepts", N'(n_acc - base_acc), N'(10000));
        check("rand_queue_empty", N'(exp_q.size()), '0);
        check("total_in_eq_out", N'(n_out), N'(n_acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
